// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions, condition codes, controller FSM states
// and small opcode-class helpers shared by alu, alu_cond_eval and alu_ctrl.
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                           OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                           OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                           OP_ORR = 4'hC, OP_PAS = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
    localparam int NEG = 3, ZER = 2, CAR = 1, OVR = 0;
    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
                           CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
                           CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
                           CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE;
    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_RESP} state_e;
    function automatic logic is_logic(input logic [3:0] op);
        return !(op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN});
    endfunction
    function automatic logic is_test(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction
    // The high word of a wide op must consume the carry produced by the low word.
    function automatic logic [3:0] hi_op(input logic [3:0] op);
        return (op == OP_ADD || op == OP_CMN) ? OP_ADC :
               (op == OP_SUB || op == OP_CMP) ? OP_SBC :
               (op == OP_RSB) ? OP_RSC : op;
    endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU with carry in, producing result and NZCV.
// Ports: a_i/b_i operands, op_i opcode, c_i carry in, y_o result, f_o {N,Z,C,V}.
// Logical ops report C = c_i and V = 0; the controller decides what to keep.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    input  logic        c_i,
    output logic [31:0] y_o,
    output logic [3:0]  f_o
);
    logic [31:0] x, y;
    logic        ci;
    logic [32:0] sum;
    always_comb begin
        x  = a_i;
        y  = b_i;
        ci = 1'b0;
        case (op_i)
            OP_SUB, OP_CMP: begin y = ~b_i; ci = 1'b1; end
            OP_RSB:         begin x = b_i; y = ~a_i; ci = 1'b1; end
            OP_ADC:         ci = c_i;
            OP_SBC:         begin y = ~b_i; ci = c_i; end
            OP_RSC:         begin x = b_i; y = ~a_i; ci = c_i; end
            default:        ;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        case (op_i)
            OP_AND, OP_TST: y_o = a_i & b_i;
            OP_EOR, OP_TEQ: y_o = a_i ^ b_i;
            OP_ORR:         y_o = a_i | b_i;
            OP_PAS:         y_o = b_i;
            OP_BIC:         y_o = a_i & ~b_i;
            OP_MVN:         y_o = ~b_i;
            default:        y_o = sum[31:0];
        endcase
        f_o[NEG] = y_o[31];
        f_o[ZER] = y_o == 32'd0;
        f_o[CAR] = is_logic(op_i) ? c_i : sum[32];
        f_o[OVR] = is_logic(op_i) ? 1'b0 : (x[31] == y[31]) && (sum[31] != x[31]);
    end
endmodule

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: ARM condition-code test against NZCV (built only with ALU_CTRL_COND_EN).
// Ports: cond_i condition code, flags_i {N,Z,C,V}, pass_o condition holds.
`ifdef ALU_CTRL_COND_EN
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;
    always_comb begin
        case (cond_i)
            CC_EQ:   pass_o = z;
            CC_NE:   pass_o = !z;
            CC_CS:   pass_o = c;
            CC_CC:   pass_o = !c;
            CC_MI:   pass_o = n;
            CC_PL:   pass_o = !n;
            CC_VS:   pass_o = v;
            CC_VC:   pass_o = !v;
            CC_HI:   pass_o = c && !z;
            CC_LS:   pass_o = !c || z;
            CC_GE:   pass_o = n == v;
            CC_LT:   pass_o = n != v;
            CC_GT:   pass_o = !z && (n == v);
            CC_LE:   pass_o = z || (n != v);
            default: pass_o = 1'b1;
        endcase
    end
endmodule
`endif

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one shared 32-bit alu for narrow (1 step) or wide (2 step)
// ops, owns the NZCV register and returns result/flags over valid/ready.
// Ports: req_* request channel, rsp_* response channel, flags_q NZCV register.
// Macro ALU_CTRL_COND_EN adds req_cond/rsp_skip for conditional execution.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic        req_s,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
`ifdef ALU_CTRL_COND_EN
    input  logic [3:0]  req_cond,
    output logic        rsp_skip,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  flags_q
);
    state_e      state_q;
    logic [3:0]  op_q, f_lo_q, rsp_flags_q, flags_d, alu_op, alu_f;
    logic        wide_q, s_q, hi, alu_c, wr, pass;
    logic [63:0] a_q, b_q, res_q;
    logic [31:0] alu_a, alu_b, alu_y;
`ifdef ALU_CTRL_COND_EN
    logic        skip_q;
    alu_cond_eval u_cond (.cond_i(req_cond), .flags_i(flags_q), .pass_o(pass));
    assign rsp_skip = skip_q;
`else
    assign pass = 1'b1;
`endif
    alu u_alu (.a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .c_i(alu_c), .y_o(alu_y), .f_o(alu_f));
    assign req_ready  = state_q == ST_IDLE;
    assign rsp_valid  = state_q == ST_RESP;
    assign rsp_result = res_q;
    assign rsp_flags  = rsp_flags_q;
    always_comb begin
        hi     = state_q == ST_HI;
        alu_a  = hi ? a_q[63:32] : a_q[31:0];
        alu_b  = hi ? b_q[63:32] : b_q[31:0];
        alu_op = hi ? hi_op(op_q) : op_q;
        alu_c  = hi ? f_lo_q[CAR] : flags_q[CAR];
        wr     = s_q || is_test(op_q);
        // Wide Z spans both words; logical ops leave C and V architectural.
        flags_d = {alu_f[NEG], hi ? (alu_f[ZER] & f_lo_q[ZER]) : alu_f[ZER],
                   is_logic(op_q) ? flags_q[CAR:OVR] : alu_f[CAR:OVR]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            wide_q      <= 1'b0;
            s_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            f_lo_q      <= '0;
            rsp_flags_q <= '0;
            flags_q     <= '0;
`ifdef ALU_CTRL_COND_EN
            skip_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    op_q        <= req_op;
                    wide_q      <= req_wide;
                    s_q         <= req_s;
                    a_q         <= req_a;
                    b_q         <= req_b;
                    // Preloaded with the skip response; executed ops overwrite it.
                    res_q       <= '0;
                    rsp_flags_q <= flags_q;
                    state_q     <= pass ? ST_LO : ST_RESP;
`ifdef ALU_CTRL_COND_EN
                    skip_q      <= !pass;
`endif
                end
                ST_LO: begin
                    res_q[31:0] <= alu_y;
                    f_lo_q      <= alu_f;
                    if (wide_q) begin
                        state_q <= ST_HI;
                    end else begin
                        rsp_flags_q <= flags_d;
                        if (wr) flags_q <= flags_d;
                        state_q <= ST_RESP;
                    end
                end
                ST_HI: begin
                    res_q[63:32] <= alu_y;
                    rsp_flags_q  <= flags_d;
                    if (wr) flags_q <= flags_d;
                    state_q <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: self-checking bench for alu_ctrl with an arithmetic reference model.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_wide = 1'b0, req_s = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  req_op = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic        req_ready, rsp_valid;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags, flags_q;
    logic [3:0]  mflags = '0;
    int          tests = 0, fails = 0;
`ifdef ALU_CTRL_COND_EN
    logic [3:0]  req_cond = CC_AL, cond_sel = CC_AL;
    logic        rsp_skip, last_skip = 1'b0;
`endif

    alu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wide(req_wide), .req_s(req_s), .req_a(req_a), .req_b(req_b),
`ifdef ALU_CTRL_COND_EN
        .req_cond(req_cond), .rsp_skip(rsp_skip),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: exact integer arithmetic over the full operand width.
    function automatic logic [67:0] model(input logic [3:0] op, input logic wide,
                                          input logic [63:0] a, input logic [63:0] b, input logic [3:0] f);
        logic signed [65:0] ua, ub, sa, sb, eu, es, lim, ci, one;
        logic [63:0] r;
        logic n, z, c, v;
        one = 66'sd1;
        lim = wide ? (one <<< 64) : (one <<< 32);
        ua  = wide ? {2'b0, a} : {34'b0, a[31:0]};
        ub  = wide ? {2'b0, b} : {34'b0, b[31:0]};
        sa  = wide ? {{2{a[63]}}, a} : {{34{a[31]}}, a[31:0]};
        sb  = wide ? {{2{b[63]}}, b} : {{34{b[31]}}, b[31:0]};
        ci  = (op == OP_ADC || op == OP_SBC || op == OP_RSC) ? {65'b0, f[1]} :
              (op == OP_ADD || op == OP_CMN) ? 66'sd0 : one;
        c = f[1];
        v = f[0];
        es = '0;
        case (op)
            OP_ADD, OP_ADC, OP_CMN: begin eu = ua + ub + ci; es = sa + sb + ci; c = eu >= lim; end
            OP_SUB, OP_SBC, OP_CMP: begin eu = ua - ub - (one - ci); es = sa - sb - (one - ci); c = eu >= 0; end
            OP_RSB, OP_RSC:         begin eu = ub - ua - (one - ci); es = sb - sa - (one - ci); c = eu >= 0; end
            OP_AND, OP_TST:         eu = ua & ub;
            OP_EOR, OP_TEQ:         eu = ua ^ ub;
            OP_ORR:                 eu = ua | ub;
            OP_PAS:                 eu = ub;
            OP_BIC:                 eu = ua & ~ub;
            default:                eu = ~ub & (lim - one);
        endcase
        if (!(op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_PAS, OP_BIC, OP_MVN}))
            v = (es >= (lim >>> 1)) || (es < -(lim >>> 1));
        r = wide ? eu[63:0] : {32'b0, eu[31:0]};
        n = wide ? r[63] : r[31];
        z = r == 64'd0;
        return {r, n, z, c, v};
    endfunction

    task automatic issue(input logic [3:0] op, input logic wide, input logic s, input logic [63:0] a,
                         input logic [63:0] b, input int hold, output int lat, output logic [63:0] res,
                         output logic [3:0] fl, output logic ok);
        logic [3:0] fq;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_wide = wide; req_s = s; req_a = a; req_b = b;
`ifdef ALU_CTRL_COND_EN
        req_cond = cond_sel;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_wide = 1'($urandom); req_s = 1'($urandom);
        req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
`ifdef ALU_CTRL_COND_EN
        req_cond = 4'($urandom);
`endif
        ok  = !req_ready;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (req_ready) ok = 1'b0;
        end
`ifdef ALU_CTRL_COND_EN
        last_skip = rsp_skip;
`endif
        res = rsp_result; fl = rsp_flags; fq = flags_q;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_result !== res || rsp_flags !== fl || flags_q !== fq) ok = 1'b0;
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        if (!req_ready || rsp_valid) ok = 1'b0;
`ifdef ALU_CTRL_COND_EN
        req_cond = cond_sel;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready, rsp_valid, rsp_result, rsp_flags, flags_q} !== {1'b1, 1'b0, 64'd0, 4'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b res=%h fl=%h fq=%h, want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_result, rsp_flags, flags_q);
        end
        rst_n = 1'b1;
        mflags = '0;
    endtask

    task automatic test_directed;
        logic [63:0] ra [5] = '{64'd5, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0};
        logic [3:0]  rf [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0111, 4'b0111};
        logic [3:0]  rq [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0111, 4'b0111};
        logic [3:0]  ops [5] = '{OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_EOR};
        logic        wd [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        sf [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] av [5] = '{64'd12, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'h8000_0000, 64'h1F};
        logic [63:0] bv [5] = '{64'd7, 64'd1, 64'd1, 64'h8000_0000, 64'h1F};
        int lat; logic [63:0] res; logic [3:0] fl; logic ok;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], wd[i], sf[i], av[i], bv[i], 0, lat, res, fl, ok);
            tests++;
            if (res !== ra[i] || fl !== rf[i] || flags_q !== rq[i] || lat != (wd[i] ? 3 : 2) || !ok) begin
                fails++;
                $display("FAIL directed%0d: res=%h fl=%b fq=%b lat=%0d ok=%b, want res=%h fl=%b fq=%b lat=%0d ok=1",
                         i, res, fl, flags_q, lat, ok, ra[i], rf[i], rq[i], wd[i] ? 3 : 2);
            end
        end
        mflags = 4'b0111;
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] res, ea; logic [3:0] fl; logic ok; logic [67:0] e;
        ea = {$urandom, $urandom};
        e  = model(OP_ORR, 1'b0, ea, 64'h0F0F, mflags);
        issue(OP_ORR, 1'b0, 1'b0, ea, 64'h0F0F, 5, lat, res, fl, ok);
        tests++;
        if ({res, fl} !== e || !ok || lat != 2) begin
            fails++;
            $display("FAIL backpressure: res=%h fl=%b ok=%b lat=%0d, want res=%h fl=%b ok=1 lat=2",
                     res, fl, ok, lat, e[67:4], e[3:0]);
        end
    endtask

    task automatic test_random;
        int lat; logic [63:0] res, a, b; logic [3:0] fl, op; logic ok, wide, s; logic [67:0] e;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom); wide = 1'($urandom); s = 1'($urandom);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) b = {32'd0, $urandom_range(0, 3)};
            e = model(op, wide, a, b, mflags);
            issue(op, wide, s, a, b, $urandom_range(0, 2), lat, res, fl, ok);
            if (s || op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN}) mflags = e[3:0];
            tests++;
            if ({res, fl} !== e || flags_q !== mflags || lat != (wide ? 3 : 2) || !ok) begin
                fails++;
                $display("FAIL random%0d op=%h w=%b s=%b a=%h b=%h: res=%h fl=%b fq=%b lat=%0d ok=%b, want res=%h fl=%b fq=%b lat=%0d",
                         i, op, wide, s, a, b, res, fl, flags_q, lat, ok, e[67:4], e[3:0], mflags, wide ? 3 : 2);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        logic [63:0] exp_res;
        for (int w = 0; w < 2; w++) begin
            acc.delete();
            exp_res = w ? 64'h0000_0001_0000_0000 : 64'd3;
            @(negedge clk);
            req_valid = 1'b1; req_op = OP_ADD; req_wide = 1'(w); req_s = 1'b0;
            req_a = w ? 64'hFFFF_FFFF : 64'd1; req_b = w ? 64'd1 : 64'd2;
            rsp_ready = 1'b1;
            for (int e = 0; e < 13; e++) begin
                if (req_ready) acc.push_back(e);
                if (rsp_valid) begin
                    tests++;
                    if (rsp_result !== exp_res) begin
                        fails++;
                        $display("FAIL b2b_result w=%0d: got %h want %h", w, rsp_result, exp_res);
                    end
                end
                @(negedge clk);
            end
            req_valid = 1'b0;
            repeat (6) @(negedge clk);
            rsp_ready = 1'b0;
            tests++;
            if (acc.size() != (w ? 4 : 5)) begin
                fails++;
                $display("FAIL b2b_count w=%0d: got %0d accepts want %0d", w, acc.size(), w ? 4 : 5);
            end
            for (int i = 1; i < acc.size(); i++) begin
                tests++;
                if (acc[i] - acc[i-1] != (w ? 4 : 3)) begin
                    fails++;
                    $display("FAIL b2b_interval w=%0d: got %0d want %0d", w, acc[i] - acc[i-1], w ? 4 : 3);
                end
            end
        end
    endtask

`ifdef ALU_CTRL_COND_EN
    task automatic test_cond;
        int lat; logic [63:0] res; logic [3:0] fl; logic ok;
        cond_sel = CC_AL;
        issue(OP_CMP, 1'b0, 1'b0, 64'd5, 64'd5, 0, lat, res, fl, ok);
        mflags = 4'b0110;
        cond_sel = CC_NE;
        issue(OP_ADD, 1'b0, 1'b1, 64'd2, 64'd3, 1, lat, res, fl, ok);
        tests++;
        if (res !== 64'd0 || fl !== 4'b0110 || flags_q !== 4'b0110 || lat != 1 || last_skip !== 1'b1 || !ok) begin
            fails++;
            $display("FAIL cond_skip: res=%h fl=%b fq=%b lat=%0d skip=%b ok=%b, want 0 0110 0110 1 1 1",
                     res, fl, flags_q, lat, last_skip, ok);
        end
        cond_sel = CC_EQ;
        issue(OP_ADD, 1'b0, 1'b1, 64'd2, 64'd3, 0, lat, res, fl, ok);
        mflags = 4'b0000;
        tests++;
        if (res !== 64'd5 || flags_q !== 4'b0000 || lat != 2 || last_skip !== 1'b0 || !ok) begin
            fails++;
            $display("FAIL cond_pass: res=%h fq=%b lat=%0d skip=%b ok=%b, want 5 0000 2 0 1",
                     res, flags_q, lat, last_skip, ok);
        end
        cond_sel = CC_AL;
    endtask
`endif

    task automatic test_reset_mid;
        int lat; logic [63:0] res; logic [3:0] fl; logic ok, seen;
        issue(OP_CMP, 1'b0, 1'b0, 64'd5, 64'd5, 0, lat, res, fl, ok);
        tests++;
        if (flags_q !== 4'b0110) begin
            fails++;
            $display("FAIL pre_reset_flags: got %b want 0110", flags_q);
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_wide = 1'b1; req_s = 1'b1;
        req_a = 64'h1234_5678_9ABC_DEF0; req_b = 64'h1111_1111_1111_1111;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, rsp_valid, flags_q, rsp_result} !== {1'b1, 1'b0, 4'd0, 64'd0}) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b vld=%b fq=%b res=%h, want 1 0 0000 0", req_ready, rsp_valid, flags_q, rsp_result);
        end
        @(negedge clk); rst_n = 1'b1;
        mflags = '0;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen |= rsp_valid; end
        tests++;
        if (seen !== 1'b0 || flags_q !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_noresp: rsp_valid seen=%b fq=%b, want 0 0000", seen, flags_q);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
`ifdef ALU_CTRL_COND_EN
        test_cond();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller for the 32-bit `alu` datapath. It accepts one operation at a time over a valid/ready request channel and drives a single shared `alu` instance, for one cycle for narrow (32-bit) operations or two cycles for wide (64-bit) operations using the low/high carry chain. It owns the architectural NZCV flag register and returns the result and flags on a valid/ready response channel.

## Interface
- No parameters; widths fixed (32-bit ALU, 64-bit wide operands).
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  4  ALU opcode (AND 0 … MVN F, as in `alu_pkg`)
- req_wide  in  1  1 = 64-bit operation
- req_s  in  1  write flags (ignored for TST/TEQ/CMP/CMN, which always write)
- req_a, req_b  in  64  operands; narrow uses [31:0]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  result; narrow → [63:32] = 0
- rsp_flags  out  4  flag value after this op {N,Z,C,V} = bits 3..0
- flags_q  out  4  architectural flag register

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE: req_ready=1. On req_valid, capture op/wide/s/a/b and go to LO.
- LO: ALU gets a[31:0], b[31:0], op, carry=flags_q[C]. Latch out→res_lo, flags→f_lo. Narrow → RESP; wide → HI.
- HI: ALU gets a[63:32], b[63:32], carry=f_lo[C]. Op remap: ADD/CMN→ADC, SUB/CMP→SBC, RSB→RSC; all other ops are unchanged. Latch res_hi.
- Final flags: N and V come from the last step, C from the last step, and Z = Z_last for narrow or Z_lo & Z_hi for wide.
- Logical ops (AND, EOR, TST, TEQ, ORR, PAS, BIC, MVN): C and V keep the flags_q value; only N and Z are updated.
- flags_q is written with the final flags on the transition into RESP when req_s=1 or the op is TST/TEQ/CMP/CMN. Otherwise it is unchanged.
- rsp_flags is always the final flag value, whether or not it is written to flags_q.
- RESP: rsp_valid=1, outputs held stable. On rsp_ready → IDLE.
- Test ops still return the ALU output on rsp_result.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_flags=0, flags_q=0.
- Latency, accept edge to rsp_valid high: narrow 2 cycles, wide 3 cycles.
- Minimum issue interval: narrow 3 cycles, wide 4 cycles.
- req_ready is low from the accept edge until the cycle after the response handshake. There is no overlap.
- Backpressure: rsp_valid stays asserted and all rsp_* stay unchanged until rsp_ready. flags_q does not change during RESP.
- Async reset mid-operation (LO, HI or RESP): the operation is dropped, flags_q is cleared, and no response is produced.
- Request fields are sampled only on the accept edge. Later changes to them are ignored.

## Configuration
- `ALU_CTRL_COND_EN` defined: adds input req_cond[3:0] (ARM codes EQ 0 … LE D, AL E, F treated as AL) and output rsp_skip.
  - The condition is evaluated against flags_q at accept.
  - If it fails: IDLE→RESP directly (latency 1), rsp_result=0, rsp_flags=flags_q, rsp_skip=1, flags_q unchanged.
  - If it passes: normal flow with rsp_skip=0.
- Macro undefined: req_cond and rsp_skip are absent, and every request executes.

## Structure
- `alu_pkg`: opcode constants, flag indices (NEG 3, ZER 2, CAR 1, OVR 0), condition codes, FSM state enum.
- One `alu` instance is shared between the LO and HI steps. Its opcode and carry inputs are muxed by state.
- Sub-module `alu_cond_eval` (4-bit cond + NZCV → pass) is compiled only under `ALU_CTRL_COND_EN`.

## Test plan
- Narrow SUB a=12 b=7 s=1 → after 2 cycles result=5, rsp_flags N=0 Z=0 V=0; flags_q updated; req_ready=0 throughout.
- Wide ADD a=0x0000_0000_FFFF_FFFF b=1 s=1 → after 3 cycles result=0x0000_0001_0000_0000, N=0 Z=0 V=0.
- Wide SUB a=0x0000_0001_0000_0000 b=1 → result=0x0000_0000_FFFF_FFFF, Z=0. With s=0, flags_q is unchanged.
- Set flags_q C=1 V=1, then EOR a=b=0x1F s=1 → result=0, Z=1, N=0, C=1, V=1 retained.
- Hold rsp_ready=0 for 5 cycles after rsp_valid → result and flags stable, req_ready=0. Then assert rsp_ready → IDLE next cycle. Pull rst_n low during HI → IDLE, flags_q=0, no response.
- `ALU_CTRL_COND_EN`: CMP 5,5 (Z=1), then ADD cond=NE → rsp_skip=1, result=0, latency 1, flags_q still Z=1. Then ADD cond=EQ 2+3 → result=5.
